// File: rtl/spsram_bist_pkg.sv
// Shared definitions for the SRAM built-in self-test: FSM encodings,
// pattern-select constants and the read-latency range check.
package spsram_bist_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR0  = 3'd1;
  localparam logic [2:0] ST_RD0  = 3'd2;
  localparam logic [2:0] ST_WT0  = 3'd3;
  localparam logic [2:0] ST_WR1  = 3'd4;
  localparam logic [2:0] ST_RD1  = 3'd5;
  localparam logic [2:0] ST_WT1  = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    WR0  = ST_WR0,
    RD0  = ST_RD0,
    WT0  = ST_WT0,
    WR1  = ST_WR1,
    RD1  = ST_RD1,
    WT1  = ST_WT1,
    DONE = ST_DONE
  } state_t;

  // Pattern select: PAT0 writes the address itself, PAT1 its complement.
  localparam logic PAT0 = 1'b0;
  localparam logic PAT1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/spsram_bist_if.sv
// Single-port SRAM bus (cen/wen/oen, address, write and read data).
// The BIST is the master; the SRAM macro (or its model) is the slave.
// Protocol: an access happens on a posedge where cen=1; wen=1 writes wdata
// to addr, oen=1 reads addr and rdata carries the word RD_LAT cycles later.
// wen and oen are never both 1.
interface spsram_bist_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cen;
  logic          wen;
  logic          oen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output cen, output wen, output oen, output addr, output wdata, input rdata);
  modport slave  (input cen, input wen, input oen, input addr, input wdata, output rdata);
endinterface

// File: rtl/spsram_bist_chk.sv
// Read-back checker: delays {valid, addr, expected} by RD_LAT cycles so each
// entry lines up with its read data, then counts mismatches and captures the
// first failing address/expected/got.
module spsram_bist_chk
  import spsram_bist_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 1,
  parameter int EW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] exp,
  input  logic [DW-1:0] rdata,
  output logic          fail,
  output logic [EW-1:0] err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got
);

  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]     adr_q [RD_LAT];
  logic [DW-1:0]     exp_q [RD_LAT];
  logic              hit;

  assign hit = vld_q[RD_LAT-1] && (rdata != exp_q[RD_LAT-1]);

  // Expected-data pipeline; stage RD_LAT-1 meets the returning read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        adr_q[i] <= '0;
        exp_q[i] <= '0;
      end
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push;
      adr_q[0] <= addr;
      exp_q[0] <= exp;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  // Saturating error count and first-mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (clear) begin
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (hit) begin
      if (err_cnt != {EW{1'b1}}) err_cnt <= err_cnt + EW'(1);
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= adr_q[RD_LAT-1];
        fail_exp  <= exp_q[RD_LAT-1];
        fail_got  <= rdata;
      end
    end
  end

endmodule

// File: rtl/spsram_bist.sv
// SRAM BIST master: on start, writes the address pattern, reads it back,
// drains, then repeats with the complemented pattern. Holds the FSM and the
// address/wait counter; comparison lives in spsram_bist_chk.
module spsram_bist
  import spsram_bist_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 1,
  parameter int EW     = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_fail,
  output logic [EW-1:0] o_err_cnt,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_exp,
  output logic [DW-1:0] o_fail_got,
  spsram_bist_if.master sram,
  output state_t        dbg_state
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("spsram_bist: RD_LAT must be within 1..4");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          cen, wen, oen;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] wdata;
  logic          push, clear, pat_sel;
  logic [DW-1:0] p0, pat;

  // Same counter serves as address in WR/RD and as wait counter in WT.
  assign p0  = DW'(cnt_q);
  assign pat = (pat_sel == PAT1) ? ~p0 : p0;

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and bus drive; bus is idle (all zero) outside WR/RD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    cen      = 1'b0;
    wen      = 1'b0;
    oen      = 1'b0;
    bus_addr = '0;
    wdata    = '0;
    push     = 1'b0;
    clear    = 1'b0;
    pat_sel  = (state_q == WR1 || state_q == RD1) ? PAT1 : PAT0;
    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = WR0;
          clear   = 1'b1;
        end
      end
      WR0, WR1: begin
        cen      = 1'b1;
        wen      = 1'b1;
        bus_addr = cnt_q;
        wdata    = pat;
        cnt_d    = cnt_q + AW'(1);
        if (&cnt_q) state_d = (state_q == WR0) ? RD0 : RD1;
      end
      RD0, RD1: begin
        cen      = 1'b1;
        oen      = 1'b1;
        bus_addr = cnt_q;
        push     = 1'b1;
        cnt_d    = cnt_q + AW'(1);
        if (&cnt_q) state_d = (state_q == RD0) ? WT0 : WT1;
      end
      WT0, WT1: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(RD_LAT - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == WT0) ? WR1 : DONE;
        end
      end
    endcase
  end

  assign sram.cen   = cen;
  assign sram.wen   = wen;
  assign sram.oen   = oen;
  assign sram.addr  = bus_addr;
  assign sram.wdata = wdata;

  assign o_busy    = (state_q != IDLE) && (state_q != DONE);
  assign o_done    = (state_q == DONE);
  assign dbg_state = state_q;

  spsram_bist_chk #(
    .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .EW(EW)
  ) u_chk (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (clear),
    .push     (push),
    .addr     (bus_addr),
    .exp      (pat),
    .rdata    (sram.rdata),
    .fail     (o_fail),
    .err_cnt  (o_err_cnt),
    .fail_addr(o_fail_addr),
    .fail_exp (o_fail_exp),
    .fail_got (o_fail_got)
  );

endmodule

// File: tb/tb_spsram_bist.sv
// Testbench for spsram_bist: SRAM model with injectable faults, a write
// scoreboard on the bus, table-driven full runs and a mid-run reset sequence.
module tb_spsram_bist;
  import spsram_bist_pkg::*;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int RD_LAT   = 1;
  localparam int EW       = 8;
  localparam int DEPTH    = 1 << AW;
  localparam int EXP_BUSY = 4 * DEPTH + 2 * RD_LAT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, fail;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;
  state_t        dbg_state;

  spsram_bist_if #(.AW(AW), .DW(DW)) sram_bus ();

  spsram_bist #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .EW(EW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_fail     (fail),
    .o_err_cnt  (err_cnt),
    .o_fail_addr(fail_addr),
    .o_fail_exp (fail_exp),
    .o_fail_got (fail_got),
    .sram       (sram_bus.master),
    .dbg_state  (dbg_state)
  );

  // ---------------- SRAM model ----------------
  // fault_mode: 0 none, 1 addr 5 bit0 stuck at 1, 2 addr 3/9 read DEADBEEF
  int          fault_mode = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = mem[a];
    if (fault_mode == 1 && a == AW'(5)) d[0] = 1'b1;
    if (fault_mode == 2 && (a == AW'(3) || a == AW'(9))) d = 32'hDEADBEEF;
    return d;
  endfunction

  always @(posedge clk) begin
    if (sram_bus.cen && sram_bus.wen) mem[sram_bus.addr] <= sram_bus.wdata;
    rd_pipe[0] <= (sram_bus.cen && sram_bus.oen) ? model_rd(sram_bus.addr) : '0;
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_bus.rdata = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic load_writes();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({AW'(a), DW'(a)});
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({AW'(a), ~DW'(a)});
  endtask

  // Bus monitor: every write must match the next expected {addr, data}.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!rst && sram_bus.cen) begin
      chk("wen_oen_excl", 64'(sram_bus.wen & sram_bus.oen), 64'd0);
      if (sram_bus.wen) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr_data", 64'({sram_bus.addr, sram_bus.wdata}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  typedef struct {
    int            fault;
    int            inject;
    logic          fail;
    logic [EW-1:0] err;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fexp;
    logic [DW-1:0] fgot;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    fault_mode = v.fault;
    exp_q.delete();
    load_writes();
    pulse_start();
    // acceptance cycle: results already cleared, busy up
    chk($sformatf("v%0d_acc_busy", idx), 64'(busy), 64'd1);
    chk($sformatf("v%0d_acc_done", idx), 64'(done), 64'd0);
    chk($sformatf("v%0d_acc_clr", idx),
        64'({fail, err_cnt, fail_addr}), 64'd0);
    chk($sformatf("v%0d_acc_clr_data", idx), 64'({fail_exp, fail_got}), 64'd0);
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
      start = (n == v.inject);
    end
    start = 1'b0;
    chk($sformatf("v%0d_busy_cycles", idx), 64'(n), 64'(EXP_BUSY));
    chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d_fail", idx), 64'(fail), 64'(v.fail));
    chk($sformatf("v%0d_err_cnt", idx), 64'(err_cnt), 64'(v.err));
    chk($sformatf("v%0d_fail_addr", idx), 64'(fail_addr), 64'(v.faddr));
    chk($sformatf("v%0d_fail_exp", idx), 64'(fail_exp), 64'(v.fexp));
    chk($sformatf("v%0d_fail_got", idx), 64'(fail_got), 64'(v.fgot));
    chk($sformatf("v%0d_wr_q_empty", idx), 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_hold", idx), 64'({done, busy, fail, err_cnt}),
        64'({1'b1, 1'b0, v.fail, v.err}));
    chk($sformatf("v%0d_bus_idle", idx),
        64'({sram_bus.cen, sram_bus.wen, sram_bus.oen, sram_bus.addr, sram_bus.wdata}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, -1, 1'b0, 8'd0, 5'd0, 32'h0, 32'h0};
    vecs[1] = '{1, -1, 1'b1, 8'd1, 5'd5, 32'hFFFFFFFA, 32'hFFFFFFFB};
    vecs[2] = '{2, -1, 1'b1, 8'd4, 5'd3, 32'h00000003, 32'hDEADBEEF};
    vecs[3] = '{0, 10, 1'b0, 8'd0, 5'd0, 32'h0, 32'h0};
    vecs[4] = '{2, -1, 1'b1, 8'd4, 5'd3, 32'h00000003, 32'hDEADBEEF};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_outs", 64'({busy, done, fail, err_cnt, fail_addr}), 64'd0);
    chk("rst_bus", 64'({sram_bus.cen, sram_bus.wen, sram_bus.oen}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // reset in the middle of RD0 (DUT holds results from the last fault run)
    fault_mode = 0;
    exp_q.delete();
    load_writes();
    pulse_start();
    repeat (40) @(posedge clk);
    #1;
    chk("mid_state_rd0", 64'(dbg_state), 64'(RD0));
    chk("mid_bus_read", 64'({sram_bus.cen, sram_bus.wen, sram_bus.oen}), 64'b101);
    #2 rst = 1'b1;
    #1;
    chk("abort_bus", 64'({sram_bus.cen, sram_bus.wen, sram_bus.oen}), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("post_rst_state", 64'(dbg_state), 64'(IDLE));
    chk("post_rst_results", 64'({done, fail, err_cnt, fail_addr}), 64'd0);
    chk("post_rst_data", 64'({fail_exp, fail_got}), 64'd0);

    run_vec(5, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
